// File: rtl/fp_threshold_monitor.sv
`timescale 1ns/1ps
// Module: fp_threshold_monitor
// Purpose: Classifies IEEE-754 samples against a threshold (GT/LT/EQ/UNORD) and keeps a
//          debounced stable state for each channel.
// Latency: an accepted sample appears on out_* one cycle later. Backpressure: a result is
//          held while out_valid && !out_ready, and no new sample is accepted during that time.
// Ports:   clk/rst_n (async active-low); in_valid/in_ready/in_ch/in_data/thr sample stream;
//          out_valid/out_ready/out_ch/out_{gt,lt,eq,unord,evt} result stream;
//          stable holds 2 bits per channel (00 UNK, 01 GT, 10 LT, 11 EQ).
module fp_threshold_monitor #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int N_CH    = 4,
  parameter int DEB_CNT = 3,
  localparam int W      = 1 + EXP_W + MAN_W,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [W-1:0]      in_data,
  input  logic [W-1:0]      thr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_gt,
  output logic              out_lt,
  output logic              out_eq,
  output logic              out_unord,
  output logic              out_evt,
  output logic [2*N_CH-1:0] stable
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CNT);

  // Class codes double as the stable-state encoding; UNORD maps to UNK.
  localparam logic [1:0] CLS_UNK = 2'b00;
  localparam logic [1:0] CLS_GT  = 2'b01;
  localparam logic [1:0] CLS_LT  = 2'b10;
  localparam logic [1:0] CLS_EQ  = 2'b11;

  // ---------------- classification ----------------
  logic         a_sgn, b_sgn, a_nan, b_nan;
  logic [W-2:0] a_mag, b_mag;
  logic [1:0]   cls;

  assign a_sgn = in_data[W-1];
  assign b_sgn = thr[W-1];
  assign a_mag = in_data[W-2:0];
  assign b_mag = thr[W-2:0];
  assign a_nan = (&in_data[W-2:MAN_W]) && (|in_data[MAN_W-1:0]);
  assign b_nan = (&thr[W-2:MAN_W]) && (|thr[MAN_W-1:0]);

  always_comb begin
    cls = CLS_UNK;
    if (a_nan || b_nan) begin
      cls = CLS_UNK;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      cls = CLS_EQ;                       // +0 == -0
    end else if (a_sgn != b_sgn) begin
      cls = a_sgn ? CLS_LT : CLS_GT;
    end else if (a_mag == b_mag) begin
      cls = CLS_EQ;
    end else begin
      // Sign-magnitude: a larger magnitude is smaller when both are negative.
      cls = ((a_mag > b_mag) ^ a_sgn) ? CLS_GT : CLS_LT;
    end
  end

  // ---------------- handshake ----------------
  logic out_valid_q, out_valid_d;
  logic accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // ---------------- debounce ----------------
  logic [N_CH-1:0][1:0]       cand_q, cand_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N_CH-1:0]          stable_q, stable_d;
  logic                       evt_d;

  // Channel ids >= N_CH match no k, so they leave all channel state untouched.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    evt_d    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (accept && (in_ch == CH_W'(k))) begin
        if (cand_q[k] == cls) begin
          cnt_d[k] = (cnt_q[k] == DEB_MAX) ? DEB_MAX : cnt_q[k] + 1'b1;
        end else begin
          cand_d[k] = cls;
          cnt_d[k]  = CNT_W'(1);
        end
        if ((cnt_d[k] == DEB_MAX) && (stable_q[2*k +: 2] != cls)) begin
          stable_d[2*k +: 2] = cls;
          evt_d              = 1'b1;
        end
      end
    end
  end

  // ---------------- output register ----------------
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [3:0]      flags_q, flags_d;   // {gt, lt, eq, unord}
  logic            evt_q, evt_q_d;

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_ch_d    = out_ch_q;
    flags_d     = flags_q;
    evt_q_d     = evt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      flags_d     = {cls == CLS_GT, cls == CLS_LT, cls == CLS_EQ, a_nan || b_nan};
      evt_q_d     = evt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      flags_q     <= '0;
      evt_q       <= 1'b0;
      cand_q      <= '0;
      cnt_q       <= '0;
      stable_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      flags_q     <= flags_d;
      evt_q       <= evt_q_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_gt    = flags_q[3];
  assign out_lt    = flags_q[2];
  assign out_eq    = flags_q[1];
  assign out_unord = flags_q[0];
  assign out_evt   = evt_q;
  assign stable    = stable_q;

endmodule
